fpu_round_arbiter: RTL and testbench
====================================

Name: fpu_round_arbiter

Overview:
- Shares one rounding datapath between NUM_REQ FPU producers, such as the add, mul, div and convert units.
- Each producer presents an unrounded exponent/fraction, guard/round/sticky bits, a sign and a rounding mode.
- The block arbitrates round-robin, rounds in a 2-stage pipeline with valid/ready backpressure, and returns the result tagged with the requester index.
- It also keeps an accumulated inexact flag for the fflags CSR.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TAG_W, 2, width of OUT_TAG; must equal clog2(NUM_REQ).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- REQ_EXP_FRAC  in  NUM_REQ*65  packed; slice i is [65*i+64:65*i]; single precision uses bits [32:0].
- REQ_GUARD  in  NUM_REQ*3  packed {guard, round, sticky}.
- REQ_SIGN  in  NUM_REQ  result sign.
- REQ_RM  in  NUM_REQ*3  rounding mode: 000 RNE, 001 RZ, 010 RDN, 011 RUP, 100 RMM.
- REQ_DP  in  NUM_REQ  1 = double precision (65-bit), 0 = single precision (33-bit).
- OUT_VALID  out  1  rounded result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_EXP_FRAC  out  65  rounded exponent/fraction.
- OUT_INEXACT  out  1  guard|round|sticky of the result.
- OUT_ILLEGAL_RM  out  1  request carried a rounding mode of 101, 110 or 111.
- OUT_TAG  out  TAG_W  index of the requester that produced the result.
- FLAG_CLEAR  in  1  synchronous clear of FLAG_INEXACT_ACC.
- FLAG_INEXACT_ACC  out  1  sticky OR of OUT_INEXACT over completed transfers.
- BUSY  out  1  either pipeline stage valid.

Behaviour:
- Reset (asynchronous, RST=1) sets:
  - S1 and S2 valid to 0 and OUT_VALID=0;
  - the round-robin pointer to NUM_REQ-1, so requester 0 has first priority;
  - FLAG_INEXACT_ACC=0, OUT_EXP_FRAC=0, OUT_INEXACT=0, OUT_ILLEGAL_RM=0, OUT_TAG=0, BUSY=0, REQ_READY=0.
- Reset mid-operation drops all in-flight results silently; requesters must re-present.
- Handshake:
  - A transfer occurs when VALID and READY are both high at a rising edge.
  - Requesters hold their payload stable while VALID=1 and READY=0.
  - OUT_* are held stable while OUT_VALID=1 and OUT_READY=0.
- Arbitration:
  - Candidates are searched from pointer+1 upward, wrapping modulo NUM_REQ; the first one with REQ_VALID set wins.
  - REQ_READY[i] = win[i] & s1_accept.
  - The pointer moves to the winner only on an accepted transfer.
  - REQ_READY is combinational from REQ_VALID and the pipeline state, never from the payload.
- Pipeline:
  - S1 registers the granted payload and its tag.
  - The rounding step is combinational from S1.
  - S2 is the output register.
  - s2_accept = ~S2.valid | OUT_READY.
  - s1_accept = ~S1.valid | s2_accept.
  - Latency: accept at edge k gives OUT_VALID=1 after edge k+1.
  - Throughput is 1 per cycle when OUT_READY=1.
  - With OUT_READY=0 the pipeline holds 2 results, then REQ_READY goes all-zero.
- Rounding (add bit A, with LSB = EXP_FRAC[0] and G/R/S from REQ_GUARD):
  - RNE: A = G & (LSB|R|S).
  - RZ: A = 0.
  - RDN: A = sign & (G|R|S).
  - RUP: A = ~sign & (G|R|S).
  - RMM: A = G.
  - Modes 101/110/111: A = 0 and OUT_ILLEGAL_RM=1.
  - OUT_INEXACT = G|R|S in every mode.
- Width rules:
  - DP: OUT_EXP_FRAC = EXP_FRAC + A, modulo 2^65.
  - SP: bits [32:0] = EXP_FRAC[32:0] + A, modulo 2^33; bits [64:33] are forced to 0 regardless of the input.
  - Carry out of the top bit is discarded; the producer handles exponent overflow.
- Flag:
  - FLAG_INEXACT_ACC is set by a completed output transfer that has OUT_INEXACT=1.
  - FLAG_CLEAR in the same cycle as a setting transfer: set wins, and the flag reads 1.
  - FLAG_CLEAR with no setting transfer: the flag reads 0 next cycle.
- BUSY = S1.valid | S2.valid.

Test Plan:
- Single DP request (NUM_REQ=4):
  - Stimulus: only req 2 valid, EXP_FRAC=0x0_0000_0000_0000_0001, GUARD=100, RM=RNE, sign 0.
  - Required: REQ_READY[2]=1 in the same cycle; two edges later OUT_VALID=1, OUT_EXP_FRAC=0x2, OUT_TAG=2, OUT_INEXACT=1; FLAG_INEXACT_ACC=1 after OUT_READY.
- Mode table:
  - Stimulus: EXP_FRAC=0x10, GUARD=100, sign 1, through RNE/RZ/RDN/RUP/RMM/111.
  - Required: 0x10, 0x10, 0x11, 0x10, 0x11, 0x10; OUT_ILLEGAL_RM=1 only for 111.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, OUT_READY=1.
  - Required: grants in order 0,1,2,3,0; one grant per cycle; no requester starved.
- Backpressure:
  - Stimulus: OUT_READY=0 with 3 requests queued.
  - Required: two accepted, then REQ_READY=0; OUT held stable; OUT_READY=1 for 3 cycles drains in order with tags unchanged.
- SP wrap:
  - Stimulus: REQ_DP=0, EXP_FRAC=0x1_FFFF_FFFF with upper bits set, GUARD=111, RM=RUP, sign 0.
  - Required: OUT_EXP_FRAC=0.
- Reset mid-flight and flag clear:
  - Stimulus: assert RST with S1 and S2 full.
  - Required: outputs zero immediately (asynchronous).
  - Stimulus: FLAG_CLEAR coincident with an inexact transfer.
  - Required: flag reads 1.
  - Stimulus: FLAG_CLEAR alone.
  - Required: flag reads 0.

Source files
------------

// File: rtl/fpu_round_arbiter.sv
// Shared rounding datapath for NUM_REQ FPU producers: round-robin grant,
// 2-stage round pipeline with valid/ready, tagged result and sticky inexact flag.

module fpu_round_unit (
  input  logic [64:0] exp_frac,
  input  logic [2:0]  grs,
  input  logic        sign,
  input  logic [2:0]  rm,
  input  logic        dp,
  output logic [64:0] rounded,
  output logic        inexact,
  output logic        illegal_rm
);
  logic g, r, s, any_grs, add;

  assign {g, r, s} = grs;
  assign any_grs   = g | r | s;
  assign inexact   = any_grs;

  always_comb begin
    add        = 1'b0;
    illegal_rm = 1'b0;
    case (rm)
      3'b000:  add = g & (exp_frac[0] | r | s);
      3'b001:  add = 1'b0;
      3'b010:  add = sign & any_grs;
      3'b011:  add = ~sign & any_grs;
      3'b100:  add = g;
      default: illegal_rm = 1'b1;
    endcase
  end

  // Carry out of the top bit is dropped; the producer owns exponent overflow.
  assign rounded = dp ? exp_frac + 65'(add)
                      : {32'b0, exp_frac[32:0] + 33'(add)};
endmodule

module fpu_round_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  output logic [NUM_REQ-1:0]     REQ_READY,
  input  logic [NUM_REQ*65-1:0]  REQ_EXP_FRAC,
  input  logic [NUM_REQ*3-1:0]   REQ_GUARD,
  input  logic [NUM_REQ-1:0]     REQ_SIGN,
  input  logic [NUM_REQ*3-1:0]   REQ_RM,
  input  logic [NUM_REQ-1:0]     REQ_DP,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [64:0]            OUT_EXP_FRAC,
  output logic                   OUT_INEXACT,
  output logic                   OUT_ILLEGAL_RM,
  output logic [TAG_W-1:0]       OUT_TAG,
  input  logic                   FLAG_CLEAR,
  output logic                   FLAG_INEXACT_ACC,
  output logic                   BUSY
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [64:0]      exp_frac;
    logic [2:0]       grs;
    logic             sign;
    logic [2:0]       rm;
    logic             dp;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [64:0]      exp_frac;
    logic             inexact;
    logic             illegal_rm;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [STAGES:1]    vld_pipe;
  req_t               s1_q, grant_req;
  rsp_t               s2_q, rnd_rsp;
  logic [TAG_W-1:0]   ptr_q, win_idx;
  logic [NUM_REQ-1:0] win;
  logic               any_win, s1_accept, s2_accept, flag_q;

  function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] p, input int k);
    int sum;
    sum = int'(p) + k;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return TAG_W'(sum);
  endfunction

  assign s2_accept = ~vld_pipe[2] | OUT_READY;
  assign s1_accept = ~vld_pipe[1] | s2_accept;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    win     = '0;
    win_idx = ptr_q;
    any_win = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_win && REQ_VALID[wrap_idx(ptr_q, k)]) begin
        win[wrap_idx(ptr_q, k)] = 1'b1;
        win_idx                 = wrap_idx(ptr_q, k);
        any_win                 = 1'b1;
      end
    end
  end

  assign REQ_READY = win & {NUM_REQ{s1_accept & ~RST}};

  always_comb begin
    grant_req          = '0;
    grant_req.exp_frac = REQ_EXP_FRAC[int'(win_idx)*65 +: 65];
    grant_req.grs      = REQ_GUARD[int'(win_idx)*3 +: 3];
    grant_req.sign     = REQ_SIGN[win_idx];
    grant_req.rm       = REQ_RM[int'(win_idx)*3 +: 3];
    grant_req.dp       = REQ_DP[win_idx];
    grant_req.tag      = win_idx;
  end

  fpu_round_unit u_round (
    .exp_frac   (s1_q.exp_frac),
    .grs        (s1_q.grs),
    .sign       (s1_q.sign),
    .rm         (s1_q.rm),
    .dp         (s1_q.dp),
    .rounded    (rnd_rsp.exp_frac),
    .inexact    (rnd_rsp.inexact),
    .illegal_rm (rnd_rsp.illegal_rm)
  );
  assign rnd_rsp.tag = s1_q.tag;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      ptr_q    <= TAG_W'(NUM_REQ - 1);
    end else begin
      if (s1_accept) begin
        vld_pipe[1] <= any_win;
        if (any_win) begin
          s1_q  <= grant_req;
          ptr_q <= win_idx;
        end
      end
      if (s2_accept) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= rnd_rsp;
      end
    end
  end

  // A setting transfer beats a coincident clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                         flag_q <= 1'b0;
    else if (vld_pipe[2] & OUT_READY & s2_q.inexact) flag_q <= 1'b1;
    else if (FLAG_CLEAR)                             flag_q <= 1'b0;
  end

  assign OUT_VALID        = vld_pipe[2];
  assign OUT_EXP_FRAC     = s2_q.exp_frac;
  assign OUT_INEXACT      = s2_q.inexact;
  assign OUT_ILLEGAL_RM   = s2_q.illegal_rm;
  assign OUT_TAG          = s2_q.tag;
  assign FLAG_INEXACT_ACC = flag_q;
  assign BUSY             = |vld_pipe;
endmodule

// File: tb/tb_fpu_round_arbiter.sv
// Directed bench for fpu_round_arbiter: grant order, rounding modes,
// backpressure, SP wrap, flag set/clear and asynchronous reset.

module tb_fpu_round_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 2;

  logic                  CLK, RST;
  logic [NUM_REQ-1:0]    REQ_VALID, REQ_READY, REQ_SIGN, REQ_DP;
  logic [NUM_REQ*65-1:0] REQ_EXP_FRAC;
  logic [NUM_REQ*3-1:0]  REQ_GUARD, REQ_RM;
  logic                  OUT_VALID, OUT_READY, OUT_INEXACT, OUT_ILLEGAL_RM;
  logic [64:0]           OUT_EXP_FRAC;
  logic [TAG_W-1:0]      OUT_TAG;
  logic                  FLAG_CLEAR, FLAG_INEXACT_ACC, BUSY;

  int checks = 0;
  int errors = 0;

  logic [2:0]  modes    [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  logic [64:0] mode_exp [6] = '{65'h10, 65'h10, 65'h11, 65'h10, 65'h11, 65'h10};
  int          rr_seq   [5] = '{0, 1, 2, 3, 0};

  fpu_round_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_EXP_FRAC(REQ_EXP_FRAC), .REQ_GUARD(REQ_GUARD), .REQ_SIGN(REQ_SIGN),
    .REQ_RM(REQ_RM), .REQ_DP(REQ_DP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_EXP_FRAC(OUT_EXP_FRAC),
    .OUT_INEXACT(OUT_INEXACT), .OUT_ILLEGAL_RM(OUT_ILLEGAL_RM), .OUT_TAG(OUT_TAG),
    .FLAG_CLEAR(FLAG_CLEAR), .FLAG_INEXACT_ACC(FLAG_INEXACT_ACC), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic [64:0] ef, input logic [2:0] g,
                         input logic sg, input logic [2:0] rm, input logic dp);
    REQ_EXP_FRAC[i*65 +: 65] = ef;
    REQ_GUARD[i*3 +: 3]      = g;
    REQ_SIGN[i]              = sg;
    REQ_RM[i*3 +: 3]         = rm;
    REQ_DP[i]                = dp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; REQ_VALID = '1; REQ_EXP_FRAC = '0; REQ_GUARD = '0; REQ_SIGN = '0;
    REQ_RM = '0; REQ_DP = '0; OUT_READY = 1'b0; FLAG_CLEAR = 1'b0;
    #1;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_req_ready", REQ_READY, 0);
    check("rst_exp_frac", OUT_EXP_FRAC, 0);
    check("rst_tag", OUT_TAG, 0);
    check("rst_flag", FLAG_INEXACT_ACC, 0);
    step(); step();
    RST = 1'b0; REQ_VALID = '0;

    // Single DP request from requester 2
    set_req(2, 65'h1, 3'b100, 1'b0, 3'b000, 1'b1);
    REQ_VALID = 4'b0100;
    #1;
    check("single_ready", REQ_READY, 4'b0100);
    step(); REQ_VALID = '0; #1;
    check("single_s1_out_valid", OUT_VALID, 0);
    check("single_s1_busy", BUSY, 1);
    step();
    check("single_out_valid", OUT_VALID, 1);
    check("single_exp_frac", OUT_EXP_FRAC, 65'h2);
    check("single_tag", OUT_TAG, 2);
    check("single_inexact", OUT_INEXACT, 1);
    check("single_flag_before", FLAG_INEXACT_ACC, 0);
    OUT_READY = 1'b1;
    step();
    check("single_flag_after", FLAG_INEXACT_ACC, 1);
    check("single_drained", OUT_VALID, 0);

    // Rounding mode table on requester 0
    for (int m = 0; m < 6; m++) begin
      set_req(0, 65'h10, 3'b100, 1'b1, modes[m], 1'b1);
      REQ_VALID = 4'b0001;
      step(); REQ_VALID = '0;
      step();
      check($sformatf("mode%0d_exp_frac", m), OUT_EXP_FRAC, mode_exp[m]);
      check($sformatf("mode%0d_illegal", m), OUT_ILLEGAL_RM, (m == 5) ? 1 : 0);
      check($sformatf("mode%0d_tag", m), OUT_TAG, 0);
    end

    // Fresh reset so requester 0 leads the round-robin sequence
    RST = 1'b1; #1; RST = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 65'(i * 256 + 5), 3'b000, 1'b0, 3'b001, 1'b1);
    REQ_VALID = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      check($sformatf("rr_grant%0d", t), REQ_READY, 65'(1 << rr_seq[t]));
      if (t >= 2) begin
        check($sformatf("rr_tag%0d", t), OUT_TAG, 65'(rr_seq[t-2]));
        check($sformatf("rr_exp%0d", t), OUT_EXP_FRAC, 65'(rr_seq[t-2] * 256 + 5));
      end
      step();
    end
    REQ_VALID = '0;
    step(); step(); step();
    check("rr_drain_valid", OUT_VALID, 0);
    check("rr_drain_busy", BUSY, 0);

    // Backpressure: three queued, two accepted, then stall
    for (int i = 1; i < NUM_REQ; i++) set_req(i, 65'(32'h1000 + i), 3'b000, 1'b0, 3'b001, 1'b1);
    OUT_READY = 1'b0;
    REQ_VALID = 4'b1110; #1;
    check("bp_ready1", REQ_READY, 4'b0010);
    step(); REQ_VALID = 4'b1100; #1;
    check("bp_ready2", REQ_READY, 4'b0100);
    step(); REQ_VALID = 4'b1000; #1;
    check("bp_ready_full", REQ_READY, 4'b0000);
    check("bp_out_valid", OUT_VALID, 1);
    check("bp_tag1", OUT_TAG, 1);
    check("bp_exp1", OUT_EXP_FRAC, 65'h1001);
    step();
    check("bp_hold_ready", REQ_READY, 4'b0000);
    check("bp_hold_tag", OUT_TAG, 1);
    check("bp_hold_exp", OUT_EXP_FRAC, 65'h1001);
    OUT_READY = 1'b1; #1;
    check("bp_ready3", REQ_READY, 4'b1000);
    step(); REQ_VALID = '0; #1;
    check("bp_tag2", OUT_TAG, 2);
    check("bp_exp2", OUT_EXP_FRAC, 65'h1002);
    step();
    check("bp_tag3", OUT_TAG, 3);
    check("bp_exp3", OUT_EXP_FRAC, 65'h1003);
    step();
    check("bp_empty", OUT_VALID, 0);

    // SP wrap: upper input bits ignored, 33-bit carry dropped
    set_req(0, {32'hDEADBEEF, 33'h1_FFFF_FFFF}, 3'b111, 1'b0, 3'b011, 1'b0);
    REQ_VALID = 4'b0001;
    step(); REQ_VALID = '0;
    step();
    check("sp_valid", OUT_VALID, 1);
    check("sp_exp_frac", OUT_EXP_FRAC, 0);
    check("sp_inexact", OUT_INEXACT, 1);

    // Clear coincident with an inexact transfer, then clear alone
    FLAG_CLEAR = 1'b1;
    step();
    check("flag_set_wins", FLAG_INEXACT_ACC, 1);
    step();
    check("flag_cleared", FLAG_INEXACT_ACC, 0);
    FLAG_CLEAR = 1'b0;

    // Reset with both stages full
    OUT_READY = 1'b0;
    set_req(1, 65'h55, 3'b001, 1'b0, 3'b000, 1'b1);
    set_req(2, 65'h66, 3'b001, 1'b0, 3'b000, 1'b1);
    REQ_VALID = 4'b0010;
    step(); REQ_VALID = 4'b0100;
    step();
    check("mid_busy", BUSY, 1);
    check("mid_out_valid", OUT_VALID, 1);
    check("mid_tag", OUT_TAG, 1);
    RST = 1'b1; #1;
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_exp", OUT_EXP_FRAC, 0);
    check("mid_rst_tag", OUT_TAG, 0);
    check("mid_rst_inexact", OUT_INEXACT, 0);
    check("mid_rst_ready", REQ_READY, 0);
    RST = 1'b0; REQ_VALID = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
